mb_banco_resp: RTL

- Bank-side responder at the far end of the ATM transaction interface; the MB terminal controller is the initiator.
- Accepts one request at a time (PIN check, withdrawal, balance query, end of session) over a REQ/ACK handshake.
- Owns the account balance, PIN-attempt counter and card-block flag; returns a response code plus the current balance and its parity.

---
 rtl/mb_banco_resp.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mb_banco_resp.sv
// mb_banco_resp: bank-side responder for the MB terminal transaction link.
// Serves one PIN/withdraw/balance/end-session request per REQ/ACK handshake.
module mb_banco_resp #(
  parameter int               PIN_W      = 4,
  parameter int               SALDO_W    = 4,
  parameter logic [PIN_W-1:0] PIN_OK     = 4'b1010,
  parameter int               SALDO_INIT = 15,
  parameter int               MAX_TENT   = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ,
  input  logic [1:0]         OP,
  input  logic [PIN_W-1:0]   PIN,
  input  logic [SALDO_W-1:0] VAL,
  output logic               ACK,
  output logic [1:0]         RESP,
  output logic [SALDO_W-1:0] SALDO_OUT,
  output logic               SESSAO,
  output logic               BLOQ,
  output logic               PAR
);

  localparam int CNT_W = $clog2(MAX_TENT + 1);

  localparam logic [1:0] R_OK   = 2'b00;
  localparam logic [1:0] R_AUTH = 2'b01;
  localparam logic [1:0] R_FUND = 2'b10;
  localparam logic [1:0] R_BLOQ = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP,
    S_WAIT
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [PIN_W-1:0]   pin_q;
  logic [SALDO_W-1:0] val_q;
  logic [CNT_W-1:0]   cnt;

  logic [1:0]         code;
  logic [SALDO_W-1:0] saldo_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               sess_n;
  logic               bloq_n;

  // Next register values for the latched request; applied on the EXEC edge.
  always_comb begin
    code    = R_OK;
    saldo_n = SALDO_OUT;
    cnt_n   = cnt;
    sess_n  = SESSAO;
    bloq_n  = BLOQ;
    if (BLOQ) begin
      code = R_BLOQ;
    end else begin
      unique case (op_q)
        2'b00: begin
          if (pin_q == PIN_OK) begin
            sess_n = 1'b1;
            cnt_n  = '0;
            code   = R_OK;
          end else begin
            sess_n = 1'b0;
            cnt_n  = cnt + CNT_W'(1);
            code   = R_AUTH;
            if (cnt_n == CNT_W'(MAX_TENT)) begin
              bloq_n = 1'b1;
              code   = R_BLOQ;
            end
          end
        end
        2'b01: begin
          if (!SESSAO) begin
            code = R_AUTH;
          end else if (val_q > SALDO_OUT) begin
            code = R_FUND;
          end else begin
            saldo_n = SALDO_OUT - val_q;
            code    = R_OK;
          end
        end
        2'b10: begin
          code = SESSAO ? R_OK : R_AUTH;
        end
        2'b11: begin
          sess_n = 1'b0;
          code   = R_OK;
        end
        default: code = R_OK;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      op_q      <= '0;
      pin_q     <= '0;
      val_q     <= '0;
      cnt       <= '0;
      SALDO_OUT <= SALDO_W'(SALDO_INIT);
      SESSAO    <= 1'b0;
      BLOQ      <= 1'b0;
      ACK       <= 1'b0;
      RESP      <= R_OK;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (REQ) begin
            op_q  <= OP;
            pin_q <= PIN;
            val_q <= VAL;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          SALDO_OUT <= saldo_n;
          cnt       <= cnt_n;
          SESSAO    <= sess_n;
          BLOQ      <= bloq_n;
          RESP      <= code;
          ACK       <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          ACK   <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!REQ) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign PAR = ^SALDO_OUT;

endmodule
